// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM encoding
//   HDR_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : stream bytes assembled into one instruction word
//   word_byte_addr : word index -> word-aligned byte address
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // The instruction RAM decodes a[31:2], so the word index sits two bits up.
  function automatic logic [31:0] word_byte_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the byte-stream handshake and the instruction RAM write port.
//   s_valid/s_data/s_ready : byte source -> loader (valid/ready)
//   mem_we/mem_addr/mem_wd : loader -> instruction RAM write port
//   modport master : host/byte-source side (drives stream, observes writes)
//   modport slave  : loader side
interface imem_loader_if;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer
//   Assembles little-endian stream bytes into 32-bit instruction words.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : restart assembly at lane 0 (new load)
//   byte_en      : byte_in is accepted this cycle
//   byte_in      : stream byte; byte k of a word lands in bits [8k+7:8k]
//   word_out     : last completed word, held until the next one completes
//   word_valid   : one-cycle pulse the cycle after the lane-3 byte
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_valid
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int PART_W = 8 * (BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane;
  logic [PART_W-1:0] partial;

  // Lower lanes collect in a separate partial register so word_out only
  // changes when a full word completes; the RAM write data then stays
  // stable between writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane       <= '0;
      partial    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane    <= '0;
        partial <= '0;
      end else if (byte_en) begin
        if (lane == LANE_W'(BYTES_PER_WORD - 1)) begin
          word_out   <= {byte_in, partial};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          partial[8*lane +: 8] <= byte_in;
          lane                 <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program into the instruction RAM from a byte stream:
//   16-bit little-endian word count, then the words (little-endian).
//   Holds the CPU in reset until a load completes cleanly.
//   Parameter DEPTH : instruction RAM size in words (max loadable count)
//   clk, reset_n    : clock, synchronous active-low reset
//   start           : one-cycle pulse, begins a load from IDLE/DONE/ERR
//   bus (slave)     : s_valid/s_data/s_ready stream in,
//                     mem_we/mem_addr/mem_wd RAM write port out
//   cpu_hold        : 1 keeps the processor in reset
//   done / error    : load completed / load rejected
//   words_loaded    : words written in the current load
//   Optional macro IMEM_LOADER_CSUM_EN: a trailing XOR checksum byte
//   follows the data; mismatch ends the load in ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           cpu_hold,
  output logic           done,
  output logic           error,
  output logic [15:0]    words_loaded
);

  localparam int HDR_BITS = 8 * HDR_BYTES;
  localparam int LANE_W   = $clog2(BYTES_PER_WORD);

`ifdef IMEM_LOADER_CSUM_EN
  localparam loader_state_t AFTER_LOAD = CSUM;
`else
  localparam loader_state_t AFTER_LOAD = DONE;
`endif

  loader_state_t     state;
  loader_state_t     next_state;
  logic [HDR_BITS-1:0] count;
  logic [HDR_BITS-1:0] hdr_count;
  logic [LANE_W-1:0] phase;
  logic              accept;
  logic              start_load;
  logic              data_byte;
  logic              last_byte;
  logic              word_valid;
  logic [31:0]       word_out;
  logic [31:0]       addr_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign accept     = bus.s_valid & bus.s_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERR);
  assign data_byte  = (state == DATA) && accept;
  assign hdr_count  = {bus.s_data, count[7:0]};

  // phase mirrors the packer's lane; words_loaded has already counted the
  // previous word by the time the next lane-3 byte can arrive.
  assign last_byte = data_byte && (phase == LANE_W'(BYTES_PER_WORD - 1)) &&
                     (words_loaded == count - 16'd1);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_load),
    .byte_en    (data_byte),
    .byte_in    (bus.s_data),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  assign bus.mem_we   = word_valid;
  assign bus.mem_wd   = word_out;
  assign bus.mem_addr = addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; start is only honoured when no load is in flight
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = HDR0;
      HDR0:            if (accept) next_state = HDR1;
      HDR1: begin
        if (accept) begin
          if (hdr_count > HDR_BITS'(DEPTH)) next_state = ERR;
          else if (hdr_count == '0)         next_state = AFTER_LOAD;
          else                              next_state = DATA;
        end
      end
      DATA:            if (last_byte) next_state = AFTER_LOAD;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept) next_state = (bus.s_data == csum) ? DONE : ERR;
      end
`endif
      default:         next_state = IDLE;
    endcase
  end

  // Outputs are pure state decodes; s_ready never looks at s_valid
  always_comb begin
    bus.s_ready = (state == HDR0) || (state == HDR1) ||
                  (state == DATA) || (state == CSUM);
    done        = (state == DONE);
    error       = (state == ERR);
    cpu_hold    = (state != DONE);
  end

  // Header capture, word address and progress counters. The address is
  // latched with the lane-3 byte so it lines up with the packer's
  // registered word; words_loaded steps as the write is issued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count        <= '0;
      phase        <= '0;
      words_loaded <= '0;
      addr_q       <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum         <= '0;
`endif
    end else if (start_load) begin
      phase        <= '0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum         <= '0;
`endif
    end else begin
      if (state == HDR0 && accept) count[7:0]  <= bus.s_data;
      if (state == HDR1 && accept) count[15:8] <= bus.s_data;
      if (data_byte) begin
        phase <= phase + 1'b1;
        if (phase == LANE_W'(BYTES_PER_WORD - 1))
          addr_q <= word_byte_addr(words_loaded);
      end
      if (word_valid) words_loaded <= words_loaded + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
      if (accept && (state == HDR0 || state == HDR1 || state == DATA))
        csum <= csum ^ bus.s_data;
`endif
    end
  end

endmodule
